pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed 64-bit fetch/decode stage register: a generic pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush and bubble insertion.
- Used between any two pipeline stages (IF/ID, ID/EX, ...).
- A stall is now backpressure (down_ready low), not a dedicated hold input.
- Full throughput, with registered up_ready so no combinational ready path crosses the stage.

---
 rtl/pipe_skid_stage_if.sv | 21 ++
 rtl/pipe_skid_stage.sv | 159 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/data bundle for one side of a pipeline stage.
// The master drives valid and data; the slave drives ready.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and
// bubble insertion. up_ready, down_valid and occupancy are all registered,
// so no combinational ready path crosses the stage.
//
// Optional performance counters (stall_cnt, flush_cnt) are built only when
// the macro PIPE_SKID_PERF_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no beat held; down_data = BUBBLE_VAL, up_ready = 1
// ONE   | main_q holds the oldest beat; skid_q idle
// FULL  | main_q holds the oldest beat, skid_q the next one; up_ready = 0
module pipe_skid_stage #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_skid_stage_if.slave     up,
    pipe_skid_stage_if.master    down,
    output logic [1:0]           occupancy
`ifdef PIPE_SKID_PERF_EN
   ,output logic [31:0]          stall_cnt
   ,output logic [31:0]          flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              up_ready_q, up_ready_d;
    logic              down_valid_q, down_valid_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic up_fire;
    logic down_fire;

    assign up_fire   = up.valid & up_ready_q;
    assign down_fire = down_valid_q & down.ready;

    assign up.ready   = up_ready_q;
    assign down.valid = down_valid_q;
    assign down.data  = main_q;
    assign occupancy  = occupancy_q;

    // Next-state, storage and registered-output decode for the skid FSM.
    always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;

        if (flush) begin
            // A beat accepted this cycle is dropped along with held ones.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (up_fire) begin
                        main_d  = up.data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (up_fire && down_fire) begin
                        main_d  = up.data;
                    end else if (up_fire) begin
                        skid_d  = up.data;
                        state_d = ST_FULL;
                    end else if (down_fire) begin
                        main_d  = BUBBLE_VAL;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (down_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end

        // Outputs are decoded from the next state so they come straight
        // out of flops in the following cycle.
        up_ready_d   = (state_d != ST_FULL);
        down_valid_d = (state_d != ST_EMPTY);
        unique case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_FULL: occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State, storage and registered handshake outputs; reset wins over all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_q       <= BUBBLE_VAL;
            skid_q       <= BUBBLE_VAL;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
            occupancy_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            up_ready_q   <= up_ready_d;
            down_valid_q <= down_valid_d;
            occupancy_q  <= occupancy_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (down_valid_q && !down.ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage. The reference model treats the
// stage as a FIFO of depth 2: accept when fewer than 2 beats are held, offer
// the oldest beat, bubble when empty, and clear on flush or reset.
module tb_pipe_skid_stage;
    localparam int          DATA_W = 64;
    localparam logic [63:0] BUBBLE = 64'h0;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_skid_stage_if #(.DATA_W(DATA_W)) up_if ();
    pipe_skid_stage_if #(.DATA_W(DATA_W)) down_if ();

    pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .up        (up_if),
        .down      (down_if),
        .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
       ,.stall_cnt (stall_cnt)
       ,.flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] mq[$];
    int unsigned stall_m = 0;
    int unsigned flush_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_up_ready"},   {63'd0, up_if.ready},   {63'd0, (mq.size() < 2)});
        check({tag, "_down_valid"}, {63'd0, down_if.valid}, {63'd0, (mq.size() > 0)});
        check({tag, "_down_data"},  down_if.data, (mq.size() > 0) ? mq[0] : BUBBLE);
        check({tag, "_occupancy"},  {62'd0, occupancy},     64'(mq.size()));
`ifdef PIPE_SKID_PERF_EN
        check({tag, "_stall_cnt"},  {32'd0, stall_cnt},     {32'd0, stall_m});
        check({tag, "_flush_cnt"},  {32'd0, flush_cnt},     {32'd0, flush_m});
`endif
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then compare at the following falling edge.
    task automatic step(input string tag, input logic rn, input logic fl,
                        input logic uv, input logic [63:0] ud, input logic dr);
        logic uf, df;
        rst_n         = rn;
        flush         = fl;
        up_if.valid   = uv;
        up_if.data    = ud;
        down_if.ready = dr;
        uf = uv && (mq.size() < 2);
        df = (mq.size() > 0) && dr;
        if ((mq.size() > 0) && !dr) stall_m++;
        if (fl) flush_m++;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            stall_m = 0;
            flush_m = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (df) void'(mq.pop_front());
            if (uf) mq.push_back(ud);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        up_if.valid = 1'b0; up_if.data = '0; down_if.ready = 1'b0;
        @(negedge clk);

        // Reset then streaming.
        step("rst0", 0, 0, 0, 64'h0, 0);
        step("rst1", 0, 0, 0, 64'h0, 0);
        check("rst_occ", {62'd0, occupancy}, 64'd0);
        step("str1", 1, 0, 1, 64'h1, 1);
        check("str1_data", down_if.data, 64'h1);
        step("str2", 1, 0, 1, 64'h2, 1);
        check("str2_data", down_if.data, 64'h2);
        step("str3", 1, 0, 1, 64'h3, 1);
        check("str3_data", down_if.data, 64'h3);
        check("str3_occ", {62'd0, occupancy}, 64'd1);
        step("str4", 1, 0, 0, 64'h0, 1);

        // Backpressure into FULL, then drain in order.
        step("bp0", 1, 0, 1, 64'hA, 0);
        step("bp1", 1, 0, 1, 64'hB, 0);
        check("bp_occ", {62'd0, occupancy}, 64'd2);
        check("bp_ready", {63'd0, up_if.ready}, 64'd0);
        step("bp2", 1, 0, 1, 64'hEE, 0);
        step("bp3", 1, 0, 0, 64'h0, 1);
        check("bp_out_b", down_if.data, 64'hB);
        check("bp_ready_back", {63'd0, up_if.ready}, 64'd1);
        step("bp4", 1, 0, 0, 64'h0, 1);

        // Flush while FULL; the beat offered in that cycle is lost.
        step("fl0", 1, 0, 1, 64'hA, 0);
        step("fl1", 1, 0, 1, 64'hB, 0);
        step("fl2", 1, 1, 1, 64'hC, 0);
        check("fl_valid", {63'd0, down_if.valid}, 64'd0);
        check("fl_data", down_if.data, BUBBLE);
        step("fl3", 1, 0, 0, 64'h0, 1);

        // Drain to bubble.
        step("dr0", 1, 0, 1, 64'h5, 0);
        step("dr1", 1, 0, 0, 64'h0, 1);
        check("dr_data", down_if.data, 64'h0);

        // Reset has priority over flush.
        step("rp0", 1, 0, 1, 64'h11, 0);
        step("rp1", 1, 0, 1, 64'h22, 0);
        step("rp2", 0, 1, 1, 64'h33, 0);
        check("rp_occ", {62'd0, occupancy}, 64'd0);
`ifdef PIPE_SKID_PERF_EN
        check("rp_flush_cnt", {32'd0, flush_cnt}, 64'd0);
`endif

        // Stall and flush counting: 7 stall cycles then 3 flush cycles.
        step("pc0", 1, 0, 1, 64'h77, 1);
        for (int i = 0; i < 7; i++) step("pc_stall", 1, 0, 0, 64'h0, 0);
        for (int i = 0; i < 3; i++) step("pc_flush", 1, 1, 0, 64'h0, 1);
`ifdef PIPE_SKID_PERF_EN
        check("pc_stall_cnt", {32'd0, stall_cnt}, 64'd7);
        check("pc_flush_cnt", {32'd0, flush_cnt}, 64'd3);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 logic'($urandom_range(0, 99) != 0),
                 logic'($urandom_range(0, 24) == 0),
                 logic'($urandom_range(0, 1)),
                 {$urandom, $urandom},
                 logic'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
